// File: rtl/mem_stage_cache_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_cache_ctrl
// Memory-stage request controller sitting between the EX/MEM pipeline
// register and the data cache. It accepts one load or store at a time,
// rejects malformed requests without touching the cache, and issues legal
// requests over the cache ready/valid handshake. Address, data and command
// are held stable through miss service. The pipeline is stalled until the
// response cycle. Saturating hit and miss counters are kept.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/read/write       memory op from EX/MEM (held while stall=1)
//   req_addr, req_wdata        byte address and store data
//   stall                      combinational pipeline freeze
//   resp_valid/err/rdata       one-cycle completion pulse, error flag, load data
//   cache_is_input_valid       request strobe to the cache (REQ state only)
//   cache_addr/din/mem_read/mem_write  latched request toward the cache
//   cache_is_ready             cache accepts the strobe
//   cache_is_output_valid      cache result available, with cache_dout
//   hit_count, miss_count      saturating performance counters
// ---------------------------------------------------------------------------
module mem_stage_cache_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              cache_is_input_valid,
   output logic [ADDR_W-1:0] cache_addr,
   output logic              cache_mem_read,
   output logic              cache_mem_write,
   output logic [DATA_W-1:0] cache_din,
   input  logic              cache_is_ready,
   input  logic              cache_is_output_valid,
   input  logic [DATA_W-1:0] cache_dout,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                first_q, first_d;
   logic                iv_q, iv_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                rvalid_q, rvalid_d;
   logic                rerr_q, rerr_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [31:0]         hit_q, hit_d;
   logic [31:0]         miss_q, miss_d;
   logic                legal_s;

   // Exactly one command bit and a word-aligned address.
   function automatic logic req_is_legal(input logic rd, input logic wr,
                                         input logic [1:0] lsb);
      return (rd ^ wr) & (lsb == 2'b00);
   endfunction

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign legal_s = req_is_legal(req_read, req_write, req_addr[1:0]);

   // Next-state and next-output logic for the request FSM.
   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      iv_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      rvalid_d = 1'b0;
      rerr_d   = 1'b0;
      rdata_d  = rdata_q;
      hit_d    = hit_q;
      miss_d   = miss_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            // RESP accepts like IDLE so back-to-back ops see no bubble.
            if (req_valid) begin
               if (legal_s) begin
                  state_d = ST_REQ;
                  iv_d    = 1'b1;
                  addr_d  = req_addr;
                  din_d   = req_wdata;
                  rd_d    = req_read;
                  wr_d    = req_write;
               end else begin
                  // Rejected ops bypass the cache entirely.
                  state_d  = ST_RESP;
                  rvalid_d = 1'b1;
                  rerr_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (cache_is_ready) begin
               state_d = ST_WAIT;
               first_d = 1'b1;
            end else begin
               iv_d = 1'b1;
            end
         end
         ST_WAIT: begin
            // A result on the very first WAIT cycle is a hit.
            first_d = 1'b0;
            if (cache_is_output_valid) begin
               state_d  = ST_RESP;
               rvalid_d = 1'b1;
               if (rd_q) begin
                  rdata_d = cache_dout;
               end else begin
                  rdata_d = rdata_q;
               end
               if (first_q) begin
                  hit_d = sat_inc(hit_q);
               end else begin
                  miss_d = sat_inc(miss_q);
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         first_q  <= 1'b0;
         iv_q     <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         din_q    <= {DATA_W{1'b0}};
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= {DATA_W{1'b0}};
         hit_q    <= 32'd0;
         miss_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         iv_q     <= iv_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   // Stall covers the in-flight states and any op being accepted this cycle.
   always_comb begin
      if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
         stall = 1'b1;
      end else begin
         stall = req_valid;
      end
   end

   assign cache_is_input_valid = iv_q;
   assign cache_addr           = addr_q;
   assign cache_din            = din_q;
   assign cache_mem_read       = rd_q;
   assign cache_mem_write      = wr_q;
   assign resp_valid           = rvalid_q;
   assign resp_err             = rerr_q;
   assign resp_rdata           = rdata_q;
   assign hit_count            = hit_q;
   assign miss_count           = miss_q;

endmodule

// File: tb/tb_mem_stage_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_cache_ctrl
// Directed bench for mem_stage_cache_ctrl. The bench plays the cache: it
// raises cache_is_ready and cache_is_output_valid on cycles it schedules
// relative to request acceptance, and checks latency, handshake, data and
// counters against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_stage_cache_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid, req_read, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        stall, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        cache_is_input_valid, cache_mem_read, cache_mem_write;
   logic [31:0] cache_addr, cache_din;
   logic        cache_is_ready, cache_is_output_valid;
   logic [31:0] cache_dout;
   logic [31:0] hit_count, miss_count;

   int n_cmp  = 0;
   int n_fail = 0;

   mem_stage_cache_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .req_valid             (req_valid),
      .req_read              (req_read),
      .req_write             (req_write),
      .req_addr              (req_addr),
      .req_wdata             (req_wdata),
      .stall                 (stall),
      .resp_valid            (resp_valid),
      .resp_rdata            (resp_rdata),
      .resp_err              (resp_err),
      .cache_is_input_valid  (cache_is_input_valid),
      .cache_addr            (cache_addr),
      .cache_mem_read        (cache_mem_read),
      .cache_mem_write       (cache_mem_write),
      .cache_din             (cache_din),
      .cache_is_ready        (cache_is_ready),
      .cache_is_output_valid (cache_is_output_valid),
      .cache_dout            (cache_dout),
      .hit_count             (hit_count),
      .miss_count            (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one op at cycle T (k=0), then plays the cache: ready on cycle
   // nready+1, output valid nwait cycles into WAIT. Records what it sees.
   task automatic run_op(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] dout_v,
                         input int nready, input int nwait,
                         output int lat, output int stall_hi,
                         output int strobes, output bit stable,
                         output logic stall_resp, output logic err_resp);
      lat = -1; stall_hi = 0; strobes = 0; stable = 1'b1;
      stall_resp = 1'bx; err_resp = 1'bx;
      @(posedge clk); #2;
      req_valid = 1'b1; req_read = rd; req_write = wr;
      req_addr = addr; req_wdata = wdata;
      cache_is_ready = 1'b0; cache_is_output_valid = 1'b0; cache_dout = dout_v;
      #1;
      if (stall) stall_hi++;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #2;
         req_valid = 1'b0;
         cache_is_ready        = (k == nready + 1);
         cache_is_output_valid = (k == nready + 2 + nwait);
         #1;
         if (cache_is_input_valid) strobes++;
         if (resp_valid) begin
            lat = k; stall_resp = stall; err_resp = resp_err;
            break;
         end
         if (stall) stall_hi++;
         if (cache_addr !== addr || cache_din !== wdata ||
             cache_mem_read !== rd || cache_mem_write !== wr) stable = 1'b0;
      end
      cache_is_ready = 1'b0; cache_is_output_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      cache_is_ready = 1'b0; cache_is_output_valid = 1'b0; cache_dout = 32'd0;
      #2 reset = 1'b0;
      #2;
      n_cmp++;
      if ({resp_valid, resp_err, cache_is_input_valid, cache_mem_read,
           cache_mem_write, stall} !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000", {resp_valid,
                  resp_err, cache_is_input_valid, cache_mem_read, cache_mem_write, stall});
      end
      n_cmp++;
      if (cache_addr !== 32'd0 || cache_din !== 32'd0 || resp_rdata !== 32'd0 ||
          hit_count !== 32'd0 || miss_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr=%h din=%h rdata=%h hit=%0d miss=%0d expected all 0",
                  cache_addr, cache_din, resp_rdata, hit_count, miss_count);
      end
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #3;
      n_cmp++;
      if (resp_valid !== 1'b0 || stall !== 1'b0 || cache_is_input_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: rv=%b stall=%b iv=%b expected 0 0 0",
                  resp_valid, stall, cache_is_input_valid);
      end
   endtask

   task automatic test_cold_miss();
      int lat, shi, stb; bit stb_ok; logic sr, er;
      run_op(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 0, 8,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 11) begin
         n_fail++; $display("FAIL cold_latency: got %0d expected 11", lat);
      end
      n_cmp++;
      if (shi !== 11 || sr !== 1'b0) begin
         n_fail++; $display("FAIL cold_stall: high %0d cycles, at resp %b; expected 11, 0", shi, sr);
      end
      n_cmp++;
      if (resp_rdata !== 32'hDEAD_BEEF || er !== 1'b0) begin
         n_fail++; $display("FAIL cold_rdata: got %h err %b expected deadbeef err 0", resp_rdata, er);
      end
      n_cmp++;
      if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
         n_fail++; $display("FAIL cold_counters: hit=%0d miss=%0d expected 0 1", hit_count, miss_count);
      end
      n_cmp++;
      if (stb !== 1 || stb_ok !== 1'b1) begin
         n_fail++; $display("FAIL cold_strobe: strobes=%0d stable=%b expected 1 1", stb, stb_ok);
      end
   endtask

   task automatic test_store_load();
      int lat, shi, stb; bit stb_ok; logic sr, er;
      run_op(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0BAD_0BAD, 0, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 3 || stb_ok !== 1'b1) begin
         n_fail++; $display("FAIL store_hit: lat=%0d stable=%b expected 3 1", lat, stb_ok);
      end
      n_cmp++;
      if (resp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL store_keeps_rdata: got %h expected deadbeef", resp_rdata);
      end
      run_op(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h1234_5678, 0, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 3 || stb_ok !== 1'b1 || resp_rdata !== 32'h1234_5678) begin
         n_fail++; $display("FAIL load_hit: lat=%0d stable=%b rdata=%h expected 3 1 12345678",
                            lat, stb_ok, resp_rdata);
      end
      n_cmp++;
      if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
         n_fail++; $display("FAIL store_load_counters: hit=%0d miss=%0d expected 2 1", hit_count, miss_count);
      end
   endtask

   task automatic test_errors();
      int lat, shi, stb; bit stb_ok; logic sr, er;
      run_op(1'b1, 1'b0, 32'h0000_0042, 32'h0000_0000, 32'h0000_0000, 0, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || stb !== 0) begin
         n_fail++; $display("FAIL misaligned: lat=%0d err=%b strobes=%0d expected 1 1 0", lat, er, stb);
      end
      run_op(1'b1, 1'b1, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 0, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || stb !== 0) begin
         n_fail++; $display("FAIL both_cmd: lat=%0d err=%b strobes=%0d expected 1 1 0", lat, er, stb);
      end
      run_op(1'b0, 1'b0, 32'h0000_0048, 32'h0000_0000, 32'h0000_0000, 0, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || stb !== 0) begin
         n_fail++; $display("FAIL no_cmd: lat=%0d err=%b strobes=%0d expected 1 1 0", lat, er, stb);
      end
      n_cmp++;
      if (hit_count !== 32'd2 || miss_count !== 32'd1 || resp_rdata !== 32'h1234_5678 ||
          cache_addr !== 32'h0000_0040) begin
         n_fail++; $display("FAIL err_side_effects: hit=%0d miss=%0d rdata=%h addr=%h expected 2 1 12345678 00000040",
                            hit_count, miss_count, resp_rdata, cache_addr);
      end
   endtask

   task automatic test_ready_delay();
      int lat, shi, stb; bit stb_ok; logic sr, er;
      run_op(1'b1, 1'b0, 32'h0000_0060, 32'h0000_0000, 32'hA5A5_0060, 5, 0,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (stb !== 6) begin
         n_fail++; $display("FAIL ready_strobe_len: got %0d expected 6", stb);
      end
      n_cmp++;
      if (lat !== 8 || resp_rdata !== 32'hA5A5_0060 || hit_count !== 32'd3) begin
         n_fail++; $display("FAIL ready_delay: lat=%0d rdata=%h hit=%0d expected 8 a5a50060 3",
                            lat, resp_rdata, hit_count);
      end
   endtask

   task automatic test_reset_mid_miss();
      int lat, shi, stb; bit stb_ok; logic sr, er;
      @(posedge clk); #2;
      req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
      req_addr = 32'h0000_0040; req_wdata = 32'h0000_0000;
      @(posedge clk); #2;
      req_valid = 1'b0; cache_is_ready = 1'b1;
      @(posedge clk); #2;
      cache_is_ready = 1'b0;
      @(posedge clk); #3;
      n_cmp++;
      if (stall !== 1'b1 || cache_is_input_valid !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_miss_wait: stall=%b iv=%b rv=%b expected 1 0 0",
                            stall, cache_is_input_valid, resp_valid);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({stall, resp_valid, resp_err, cache_is_input_valid, cache_mem_read, cache_mem_write} !== 6'b000000 ||
          cache_addr !== 32'd0 || cache_din !== 32'd0 || resp_rdata !== 32'd0 ||
          hit_count !== 32'd0 || miss_count !== 32'd0) begin
         n_fail++; $display("FAIL async_reset_clear: flags=%b addr=%h rdata=%h hit=%0d miss=%0d expected all 0",
                            {stall, resp_valid, resp_err, cache_is_input_valid, cache_mem_read, cache_mem_write},
                            cache_addr, resp_rdata, hit_count, miss_count);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      run_op(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 32'hCAFE_0080, 0, 3,
             lat, shi, stb, stb_ok, sr, er);
      n_cmp++;
      if (lat !== 6 || resp_rdata !== 32'hCAFE_0080 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
         n_fail++; $display("FAIL after_reset_load: lat=%0d rdata=%h miss=%0d hit=%0d expected 6 cafe0080 1 0",
                            lat, resp_rdata, miss_count, hit_count);
      end
   endtask

   task automatic test_back_to_back();
      int resp_k[$];
      @(posedge clk); #2;
      req_read = 1'b1; req_write = 1'b0;
      req_addr = 32'h0000_0100; req_wdata = 32'h0000_0000;
      cache_is_ready = 1'b1; cache_is_output_valid = 1'b1; cache_dout = 32'h5555_0100;
      for (int k = 0; k <= 14; k++) begin
         if (k > 0) begin
            @(posedge clk); #2;
         end
         req_valid = (k <= 8);
         #1;
         if (resp_valid) resp_k.push_back(k);
      end
      cache_is_ready = 1'b0; cache_is_output_valid = 1'b0; req_valid = 1'b0;
      n_cmp++;
      if (resp_k.size() !== 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", resp_k.size());
      end else begin
         n_cmp++;
         if (resp_k[0] !== 3 || resp_k[1] !== 6 || resp_k[2] !== 9) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d %0d %0d expected 3 6 9",
                               resp_k[0], resp_k[1], resp_k[2]);
         end
      end
      n_cmp++;
      if (hit_count !== 32'd3 || miss_count !== 32'd1 || resp_rdata !== 32'h5555_0100) begin
         n_fail++; $display("FAIL b2b_counters: hit=%0d miss=%0d rdata=%h expected 3 1 55550100",
                            hit_count, miss_count, resp_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_store_load();
      test_errors();
      test_ready_delay();
      test_reset_mid_miss();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
